// File: rtl/bitserial_addsub_ctrl_if.sv
// ---------------------------------------------------------------------------
// bitserial_addsub_ctrl_if
// Command/result bundle for the bit-serial add/subtract sequencer.
//   start     : command strobe (master -> slave)
//   sub       : 0 = a+b, 1 = a-b, sampled with start (master -> slave)
//   a, b      : WIDTH-bit operands, sampled with start (master -> slave)
//   busy      : operation in progress (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
//   result    : WIDTH-bit sum/difference (slave -> master)
//   carry_out : carry out of MSB, 1 = no borrow on subtract (slave -> master)
//   overflow  : signed overflow (slave -> master)
// ---------------------------------------------------------------------------
interface bitserial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/bitserial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// bitserial_addsub_ctrl
// Time-shares a single 1-bit full adder over WIDTH cycles to perform a
// WIDTH-bit add or subtract, LSB first.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (overrides en)
//   en   : clock enable; all state holds while low
//   bus  : slave side of bitserial_addsub_ctrl_if (start/sub/a/b in,
//          busy/done/result/carry_out/overflow out, all outputs registered)
// Timing: start accepted at edge E0, RUN covers E1..E(WIDTH), the DONE
// state registers the outputs at E(WIDTH+1), so done is high in the cycle
// after that edge. busy stays high from acceptance through the done cycle.
// ---------------------------------------------------------------------------
module bitserial_addsub_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    bitserial_addsub_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic             c_msb_in;
    logic [CNT_W-1:0] cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;

    logic             s;
    logic             c_next;

    // The shared full adder: two half-adders plus an OR.
    always_comb begin
        s      = sa[0] ^ sb[0] ^ c;
        c_next = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            c        <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtract as a + ~b + 1: the +1 enters as carry-in.
                        sa     <= bus.a;
                        sb     <= bus.sub ? ~bus.b : bus.b;
                        c      <= bus.sub;
                        cnt    <= '0;
                        acc    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        // busy drops here, one edge after the done cycle,
                        // unless a new command is accepted on the same edge.
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= {s, acc[WIDTH-1:1]};
                    c   <= c_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // c here is the carry into the MSB position.
                        c_msb_in <= c;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    result_q <= acc;
                    carry_q  <= c;
                    ovf_q    <= c_msb_in ^ c;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_bitserial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bitserial_addsub_ctrl
// Scoreboard bench: the stimulus process pushes the expected result and the
// expected done cycle when a command is accepted; an independent monitor on
// the falling edge pops and compares whenever done is high.
// ---------------------------------------------------------------------------
module tb_bitserial_addsub_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prev_done = 1'b0;
    exp_t q[$];

    bitserial_addsub_ctrl_if #(.WIDTH(W)) bif ();

    bitserial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (q.size() > 0) begin
            tests++;
            if (bif.busy !== 1'b1) begin
                fails++;
                $display("FAIL busy_during_op: busy=%b required 1 (cyc %0d)", bif.busy, cyc);
            end
        end
        if (bif.done === 1'b1) begin
            tests++;
            if (prev_done === 1'b1) begin
                fails++;
                $display("FAIL done_width: done high 2 consecutive cycles (cyc %0d)", cyc);
            end
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done=1 with no operation pending (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                tests++;
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL done_cycle: got cyc %0d required %0d", cyc, e.cyc);
                end
                tests++;
                if (bif.result !== e.r) begin
                    fails++;
                    $display("FAIL result: got %02h required %02h", bif.result, e.r);
                end
                tests++;
                if (bif.carry_out !== e.co) begin
                    fails++;
                    $display("FAIL carry_out: got %b required %b (result %02h)", bif.carry_out, e.co, e.r);
                end
                tests++;
                if (bif.overflow !== e.ov) begin
                    fails++;
                    $display("FAIL overflow: got %b required %b (result %02h)", bif.overflow, e.ov, e.r);
                end
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            tests++;
            fails++;
            $display("FAIL done_late: no done by cyc %0d required at %0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        prev_done = bif.done;
    end

    // Independent reference: integer arithmetic, not bit-serial.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int ux, uy, sx, sy, t, sv;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            t    = ux - uy;
            sv   = sx - sy;
            e.co = (ux >= uy);
        end else begin
            t    = ux + uy;
            sv   = sx + sy;
            e.co = (t > 255);
        end
        e.r   = t[W-1:0];
        e.ov  = (sv > 127) || (sv < -128);
        e.cyc = 0;
        return e;
    endfunction

    // Call at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input logic [W-1:0] er, input logic eco, input logic eov,
                         input int extra, input bit push);
        exp_t e;
        bif.a     = ia;
        bif.b     = ib;
        bif.sub   = isub;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.r   = er;
            e.co  = eco;
            e.ov  = eov;
            e.cyc = cyc + W + 1 + extra;
            q.push_back(e);
        end
        @(negedge clk);
        bif.start = 1'b0;
        tests++;
        if (bif.busy !== 1'b1) begin
            fails++;
            $display("FAIL accept_busy: busy=%b required 1 after accept", bif.busy);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (bif.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL wait_done: timeout got done=%b required 1", bif.done);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b", nm, got, req);
        end
    endtask

    initial begin
        exp_t m;
        logic [W-1:0] ra, rb;
        logic         rs;

        rst       = 1'b1;
        en        = 1'b1;
        bif.start = 1'b0;
        bif.sub   = 1'b0;
        bif.a     = '0;
        bif.b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_bit("rst_busy", bif.busy, 1'b0);
        check_bit("rst_done", bif.done, 1'b0);
        check_bit("rst_carry", bif.carry_out, 1'b0);
        check_bit("rst_ovf", bif.overflow, 1'b0);
        tests++;
        if (bif.result !== 8'h00) begin
            fails++;
            $display("FAIL rst_result: got %02h required 00", bif.result);
        end

        // Basic add with signed overflow
        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1);
        wait_done();
        @(negedge clk);

        // Unsigned wrap, then back-to-back subtract issued during done
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1);
        wait_done();
        issue(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, 1);
        wait_done();
        @(negedge clk);

        // Subtract with overflow; start raised mid-RUN must be ignored
        issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1);
        repeat (3) @(negedge clk);
        bif.a     = 8'h00;
        bif.b     = 8'h55;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        check_bit("idle_after_ignored_start", bif.busy, 1'b0);
        tests++;
        if (bif.result !== 8'h7F) begin
            fails++;
            $display("FAIL result_hold: got %02h required 7F", bif.result);
        end

        // Enable stall of 3 cycles in the middle of RUN
        issue(8'h33, 8'h55, 1'b0, 8'h88, 1'b0, 1'b1, 3, 1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_done();
        @(negedge clk);

        // Reset at RUN bit 4 abandons the operation
        issue(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("abort_busy", bif.busy, 1'b0);
        check_bit("abort_done", bif.done, 1'b0);
        tests++;
        if (bif.result !== 8'h00) begin
            fails++;
            $display("FAIL abort_result: got %02h required 00", bif.result);
        end
        repeat (15) @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1);
        wait_done();

        // Randomised operations, each issued during the previous done cycle
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            m  = model(ra, rb, rs);
            issue(ra, rb, rs, m.r, m.co, m.ov, 0, 1);
            wait_done();
        end
        repeat (4) @(negedge clk);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
